// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, read-only cache controller between the CPU load
// path and a line-oriented main-memory interface.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   cpu_req, cpu_addr        CPU read request; address sampled on acceptance
//   cpu_ready                request can be accepted this cycle
//   cpu_valid                one-cycle response pulse
//   cpu_data, cpu_hit        returned word; 1 = hit, 0 = served by a fill
//   mem_req, mem_addr        line-fill request and line address {tag, index}
//   mem_ack, mem_line        fill data strobe and line (word 0 in the MSBs)
//   flush                    invalidate all lines (honoured in IDLE only)
//   hit_count, miss_count    saturating performance counters
module cache_ctrl #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int WORDS  = 4,
    parameter int LINES  = 1024,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cpu_req,
    input  logic [ADDR_W-1:0]                 cpu_addr,
    output logic                              cpu_ready,
    output logic                              cpu_valid,
    output logic [DATA_W-1:0]                 cpu_data,
    output logic                              cpu_hit,
    output logic                              mem_req,
    output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_addr,
    input  logic                              mem_ack,
    input  logic [DATA_W*WORDS-1:0]           mem_line,
    input  logic                              flush,
    output logic [CNT_W-1:0]                  hit_count,
    output logic [CNT_W-1:0]                  miss_count
);

    localparam int OFF_W   = $clog2(WORDS);
    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int LINE_W  = DATA_W * WORDS;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        MISS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]  req_addr;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [OFF_W-1:0]   req_off;
    logic               lookup_hit;
    logic               fill;

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_index = req_addr[OFF_W +: INDEX_W];
    assign req_off   = req_addr[OFF_W-1:0];

    assign lookup_hit = valid[req_index] && (tag_mem[req_index] == req_tag);
    assign fill       = (state == MISS) && mem_ack;

    // Word 0 sits in the most significant slice of a line.
    function automatic logic [DATA_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off);
        return line[LINE_W-1 - int'(off)*DATA_W -: DATA_W];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        cpu_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                // rst is folded in so the handshake stays closed during reset.
                cpu_ready = rst && !flush;
                if (!flush && cpu_req) begin
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                state_next = lookup_hit ? RESP : MISS;
            end
            MISS: begin
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                cpu_valid  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr   <= '0;
            valid      <= '0;
            cpu_data   <= '0;
            cpu_hit    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && !flush && cpu_req) begin
                req_addr <= cpu_addr;
            end

            if (state == IDLE && flush) begin
                valid <= '0;
            end else if (fill) begin
                valid[req_index] <= 1'b1;
            end

            if (state == LOOKUP) begin
                if (lookup_hit) begin
                    cpu_data <= word_sel(data_mem[req_index], req_off);
                    cpu_hit  <= 1'b1;
                    if (hit_count != '1) begin
                        hit_count <= hit_count + 1'b1;
                    end
                end else begin
                    mem_req  <= 1'b1;
                    mem_addr <= req_addr[ADDR_W-1:OFF_W];
                end
            end

            if (fill) begin
                cpu_data <= word_sel(mem_line, req_off);
                cpu_hit  <= 1'b0;
                mem_req  <= 1'b0;
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[req_index] <= mem_line;
            tag_mem[req_index]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    logic         clk;
    logic         rst;
    logic         cpu_req;
    logic [14:0]  cpu_addr;
    logic         flush;
    logic         mem_ack;
    logic [127:0] mem_line;

    logic         cpu_ready, cpu_valid, cpu_hit, mem_req;
    logic [31:0]  cpu_data;
    logic [12:0]  mem_addr;
    logic [15:0]  hit_count, miss_count;

    logic         s_ready, s_valid, s_hit, s_mem_req;
    logic [31:0]  s_data;
    logic [12:0]  s_mem_addr;
    logic [1:0]   s_hit_count, s_miss_count;

    int n_cmp;
    int n_fail;

    // Reference model: cache contents keyed by line index, plain counts.
    bit           mvalid [1024];
    int           mtag   [1024];
    logic [127:0] mline  [1024];
    int           mhits;
    int           mmisses;

    typedef struct {
        logic        got;
        logic [31:0] data;
        logic        hit;
        logic        saw_req;
        logic [12:0] req_addr;
        logic        req_stable;
        int          lat;
        int          ack_n;
        logic        ready_in_resp;
        logic        req_in_resp;
        logic        valid_after;
        logic        ready_after;
    } res_t;

    cache_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_data(cpu_data),
        .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_line(mem_line), .flush(flush),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(s_ready), .cpu_valid(s_valid), .cpu_data(s_data),
        .cpu_hit(s_hit), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
        .mem_ack(mem_ack), .mem_line(mem_line), .flush(flush),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, compared %0d failed %0d", n_cmp, n_fail);
        $fatal(1);
    end

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic model_clear();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
        mhits   = 0;
        mmisses = 0;
    endtask

    task automatic model_access(input logic [14:0] a, input logic [127:0] line,
                                output logic [31:0] ed, output logic eh);
        int t, i, o;
        logic [127:0] l;
        o  = int'(a) % 4;
        i  = (int'(a) / 4) % 1024;
        t  = int'(a) / 4096;
        eh = mvalid[i] && (mtag[i] == t);
        if (eh) begin
            mhits++;
        end else begin
            mvalid[i] = 1'b1;
            mtag[i]   = t;
            mline[i]  = line;
            mmisses++;
        end
        l  = mline[i];
        ed = 32'(l >> (32 * (3 - o)));
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        cpu_req = 1'b0;
        flush   = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_clear();
    endtask

    // Drives one read and records what the DUT did; the caller judges it.
    task automatic xact(input logic [14:0] a, input logic [127:0] line, input int ack_dly,
                        input bit flush_in_miss, output res_t r);
        int req_cnt;
        bit acked;
        r = '{default: 0};
        req_cnt = 0;
        acked   = 1'b0;
        for (int w = 0; w < 20 && !cpu_ready; w++) @(negedge clk);
        if (!cpu_ready) return;
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(negedge clk);
        cpu_req  = 1'b0;
        cpu_addr = 15'($urandom);
        for (int n = 1; n <= 100; n++) begin
            if (cpu_valid) begin
                r.got           = 1'b1;
                r.data          = cpu_data;
                r.hit           = cpu_hit;
                r.lat           = n;
                r.ready_in_resp = cpu_ready;
                r.req_in_resp   = mem_req;
                @(negedge clk);
                r.valid_after = cpu_valid;
                r.ready_after = cpu_ready;
                return;
            end
            if (mem_req) begin
                if (!r.saw_req) begin
                    r.saw_req    = 1'b1;
                    r.req_addr   = mem_addr;
                    r.req_stable = 1'b1;
                    if (flush_in_miss) flush = 1'b1;
                end else if (mem_addr !== r.req_addr) begin
                    r.req_stable = 1'b0;
                end
                if (!acked && req_cnt == ack_dly) begin
                    mem_ack  = 1'b1;
                    mem_line = line;
                    r.ack_n  = n;
                    acked    = 1'b1;
                end
                req_cnt++;
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (acked) flush = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cpu_ready, cpu_valid, cpu_hit, mem_req} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {cpu_ready, cpu_valid, cpu_hit, mem_req});
        end
        n_cmp++;
        if (cpu_data !== 32'h0 || mem_addr !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_data_addr: got %h/%h expected 0/0", cpu_data, mem_addr);
        end
        n_cmp++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d expected 0/0", hit_count, miss_count);
        end
        rst = 1'b1;
        @(negedge clk);
        model_clear();
        n_cmp++;
        if (cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b expected 1", cpu_ready);
        end
    endtask

    task automatic test_miss_hit();
        res_t r;
        logic [31:0] ed;
        logic eh;
        logic [127:0] la, lb;
        la = {32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
        lb = {32'hB0B0_0000, 32'hB1B1_1111, 32'hB2B2_2222, 32'hB3B3_3333};

        model_access(15'h0005, la, ed, eh);
        xact(15'h0005, la, 3, 1'b0, r);
        n_cmp++;
        if (r.got !== 1'b1 || r.saw_req !== 1'b1 || r.req_addr !== 13'h001) begin
            n_fail++;
            $display("FAIL first_miss_req: got valid=%b req=%b addr=%h expected 1 1 001", r.got, r.saw_req, r.req_addr);
        end
        n_cmp++;
        if (r.data !== 32'hA1A1_1111 || r.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL first_miss_data: got %h hit=%b expected a1a11111 hit=0", r.data, r.hit);
        end
        n_cmp++;
        if (r.lat - r.ack_n !== 1 || r.valid_after !== 1'b0 || r.req_stable !== 1'b1) begin
            n_fail++;
            $display("FAIL first_miss_timing: got ack_to_valid=%0d after=%b stable=%b expected 1 0 1",
                     r.lat - r.ack_n, r.valid_after, r.req_stable);
        end
        n_cmp++;
        if (miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL first_miss_count: got %0d expected 1", miss_count);
        end

        model_access(15'h0007, 128'h0, ed, eh);
        xact(15'h0007, 128'h0, 0, 1'b0, r);
        n_cmp++;
        if (r.got !== 1'b1 || r.saw_req !== 1'b0 || r.lat !== 2) begin
            n_fail++;
            $display("FAIL hit_latency: got valid=%b req=%b lat=%0d expected 1 0 2", r.got, r.saw_req, r.lat);
        end
        n_cmp++;
        if (r.data !== 32'hA3A3_3333 || r.hit !== 1'b1 || hit_count !== 16'd1) begin
            n_fail++;
            $display("FAIL hit_data: got %h hit=%b cnt=%0d expected a3a33333 1 1", r.data, r.hit, hit_count);
        end

        model_access(15'h1005, lb, ed, eh);
        xact(15'h1005, lb, 1, 1'b0, r);
        n_cmp++;
        if (r.saw_req !== 1'b1 || r.req_addr !== 13'h401 || r.data !== 32'hB1B1_1111 || r.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL conflict_fill: got req=%b addr=%h data=%h hit=%b expected 1 401 b1b11111 0",
                     r.saw_req, r.req_addr, r.data, r.hit);
        end

        model_access(15'h0005, la, ed, eh);
        xact(15'h0005, la, 2, 1'b0, r);
        n_cmp++;
        if (r.saw_req !== 1'b1 || r.data !== 32'hA1A1_1111 || miss_count !== 16'd3) begin
            n_fail++;
            $display("FAIL eviction_miss: got req=%b data=%h misses=%0d expected 1 a1a11111 3",
                     r.saw_req, r.data, miss_count);
        end
    endtask

    task automatic test_flush();
        res_t r;
        logic [31:0] ed;
        logic eh;
        logic [127:0] l;
        l = {$urandom, $urandom, $urandom, $urandom};
        for (int w = 0; w < 20 && !cpu_ready; w++) @(negedge clk);
        flush    = 1'b1;
        cpu_req  = 1'b1;
        cpu_addr = 15'h1005;
        #1;
        n_cmp++;
        if (cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %b expected 0", cpu_ready);
        end
        @(negedge clk);
        flush   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (cpu_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_not_accepted: got valid=%b req=%b expected 0 0", cpu_valid, mem_req);
        end
        foreach (mvalid[i]) mvalid[i] = 1'b0;

        model_access(15'h1005, l, ed, eh);
        xact(15'h1005, l, 2, 1'b1, r);
        n_cmp++;
        if (r.got !== 1'b1 || r.saw_req !== !eh || r.hit !== eh || r.data !== ed) begin
            n_fail++;
            $display("FAIL after_flush_miss: got req=%b hit=%b data=%h expected %b %b %h",
                     r.saw_req, r.hit, r.data, !eh, eh, ed);
        end

        model_access(15'h1006, l, ed, eh);
        xact(15'h1006, l, 0, 1'b0, r);
        n_cmp++;
        if (r.hit !== 1'b1 || r.hit !== eh || r.data !== ed) begin
            n_fail++;
            $display("FAIL flush_in_miss_ignored: got hit=%b data=%h expected %b %h", r.hit, r.data, eh, ed);
        end
    endtask

    task automatic test_reset_mid_miss();
        res_t r;
        logic [31:0] ed;
        logic eh;
        logic [127:0] l;
        bit bad;
        l = {$urandom, $urandom, $urandom, $urandom};
        for (int w = 0; w < 20 && !cpu_ready; w++) @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 15'h2008;
        @(negedge clk);
        cpu_req = 1'b0;
        for (int w = 0; w < 10 && !mem_req; w++) @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_miss_req: got %b expected 1", mem_req);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_drop: got req=%b ready=%b expected 0 0", mem_req, cpu_ready);
        end
        n_cmp++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0 || s_hit_count !== 2'd0) begin
            n_fail++;
            $display("FAIL rst_async_counters: got %0d/%0d/%0d expected 0/0/0", hit_count, miss_count, s_hit_count);
        end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        mem_ack  = 1'b1;
        mem_line = l;
        @(negedge clk);
        mem_ack = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (cpu_valid !== 1'b0 || mem_req !== 1'b0 || miss_count !== 16'd0) bad = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack_ignored: got disturbance=%b expected 0", bad);
        end
        model_access(15'h2008, l, ed, eh);
        xact(15'h2008, l, 1, 1'b0, r);
        n_cmp++;
        if (r.saw_req !== 1'b1 || r.hit !== eh || r.data !== ed) begin
            n_fail++;
            $display("FAIL post_reset_miss: got req=%b hit=%b data=%h expected 1 %b %h", r.saw_req, r.hit, r.data, eh, ed);
        end
    endtask

    task automatic test_random();
        res_t r;
        logic [31:0] ed;
        logic eh;
        logic [127:0] l;
        logic [14:0] a;
        int dly;
        for (int k = 0; k < 60; k++) begin
            a   = {3'($urandom_range(0, 7)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            l   = {$urandom, $urandom, $urandom, $urandom};
            dly = $urandom_range(0, 4);
            model_access(a, l, ed, eh);
            xact(a, l, dly, 1'b0, r);
            n_cmp++;
            if (r.got !== 1'b1 || r.data !== ed || r.hit !== eh) begin
                n_fail++;
                $display("FAIL rnd_resp[%0d] addr=%h: got valid=%b data=%h hit=%b expected 1 %h %b",
                         k, a, r.got, r.data, r.hit, ed, eh);
            end
            n_cmp++;
            if (r.saw_req !== !eh || (!eh && (r.req_addr !== a[14:2] || r.req_stable !== 1'b1))) begin
                n_fail++;
                $display("FAIL rnd_memreq[%0d]: got req=%b addr=%h stable=%b expected %b %h 1",
                         k, r.saw_req, r.req_addr, r.req_stable, !eh, a[14:2]);
            end
            n_cmp++;
            if ((eh && r.lat !== 2) || (!eh && r.lat - r.ack_n !== 1)) begin
                n_fail++;
                $display("FAIL rnd_latency[%0d]: got lat=%0d ack_at=%0d hit=%b", k, r.lat, r.ack_n, eh);
            end
            n_cmp++;
            if (r.ready_in_resp !== 1'b0 || r.req_in_resp !== 1'b0 || r.valid_after !== 1'b0 || r.ready_after !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_handshake[%0d]: got ready_resp=%b req_resp=%b valid_next=%b ready_next=%b expected 0 0 0 1",
                         k, r.ready_in_resp, r.req_in_resp, r.valid_after, r.ready_after);
            end
            n_cmp++;
            if (hit_count !== 16'(mhits) || miss_count !== 16'(mmisses) ||
                s_hit_count !== 2'(sat3(mhits)) || s_miss_count !== 2'(sat3(mmisses))) begin
                n_fail++;
                $display("FAIL rnd_counters[%0d]: got %0d/%0d sat %0d/%0d expected %0d/%0d sat %0d/%0d",
                         k, hit_count, miss_count, s_hit_count, s_miss_count,
                         mhits, mmisses, sat3(mhits), sat3(mmisses));
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        logic [31:0] ed;
        logic eh;
        logic [127:0] l;
        int pulses, last, bad_gap, bad_data;
        l = {$urandom, $urandom, $urandom, $urandom};
        model_access(15'h0C0E, l, ed, eh);
        xact(15'h0C0E, l, 1, 1'b0, r);
        pulses   = 0;
        last     = -1;
        bad_gap  = 0;
        bad_data = 0;
        cpu_req  = 1'b1;
        cpu_addr = 15'h0C0E;
        for (int n = 0; n < 20; n++) begin
            if (n == 12) cpu_req = 1'b0;
            if (cpu_valid) begin
                if (last >= 0 && n - last != 3) bad_gap++;
                if (cpu_data !== ed || cpu_hit !== 1'b1) bad_data++;
                last = n;
                pulses++;
            end
            @(negedge clk);
        end
        mhits += 4;
        n_cmp++;
        if (pulses !== 4 || bad_gap !== 0) begin
            n_fail++;
            $display("FAIL b2b_throughput: got pulses=%0d bad_gaps=%0d expected 4 0", pulses, bad_gap);
        end
        n_cmp++;
        if (bad_data !== 0 || hit_count !== 16'(mhits)) begin
            n_fail++;
            $display("FAIL b2b_data: got bad=%0d hits=%0d expected 0 %0d", bad_data, hit_count, mhits);
        end
    endtask

    task automatic test_saturation();
        res_t r;
        logic [31:0] ed;
        logic eh;
        logic [127:0] l;
        do_reset();
        l = {$urandom, $urandom, $urandom, $urandom};
        model_access(15'h3FFD, l, ed, eh);
        xact(15'h3FFD, l, 0, 1'b0, r);
        for (int k = 1; k <= 5; k++) begin
            model_access(15'h3FFD, l, ed, eh);
            xact(15'h3FFD, l, 0, 1'b0, r);
            n_cmp++;
            if (r.hit !== 1'b1 || s_hit_count !== 2'(sat3(k))) begin
                n_fail++;
                $display("FAIL sat_step[%0d]: got hit=%b cnt=%0d expected 1 %0d", k, r.hit, s_hit_count, sat3(k));
            end
        end
        n_cmp++;
        if (s_hit_count !== 2'd3 || s_miss_count !== 2'd1 || hit_count !== 16'd5) begin
            n_fail++;
            $display("FAIL sat_final: got sat=%0d/%0d wide=%0d expected 3/1 5", s_hit_count, s_miss_count, hit_count);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        flush    = 1'b0;
        mem_ack  = 1'b0;
        mem_line = '0;
        model_clear();
        test_reset();
        test_miss_hit();
        test_flush();
        test_reset_mid_miss();
        test_random();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
